// File: rtl/proc_control_fsm.sv
// Multicycle control sequencer: fetch/decode/exec/mem/write-back with memory ready handshake.
// Optional macro PROC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT instead of executing as NOP.
module proc_control_fsm #(
    parameter int RESET_STATE_HOLD = 1
) (
    input  logic        In_Clk,
    input  logic        In_Rst,
    input  logic [3:0]  In_Opcode,
    input  logic        In_Zero,
    input  logic        In_MemReady,
    output logic        Out_MemReq,
    output logic        Out_MemWrite,
    output logic        Out_IorD,
    output logic        Out_IRWrite,
    output logic        Out_PCWrite,
    output logic [1:0]  Out_PCSrc,
    output logic [1:0]  Out_ALUOp,
    output logic [1:0]  Out_ALUSrcB,
    output logic        Out_RegWrite,
    output logic [1:0]  Out_WBSel,
    output logic        Out_Retire,
    output logic [15:0] Out_RetireCount,
    output logic [2:0]  Out_State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_SI   = 4'b0101;
    localparam logic [3:0] OP_JALR = 4'b0110;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_SW   = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_JAL  = 4'b1100;
    localparam logic [3:0] OP_LUI  = 4'b1110;
    localparam logic [3:0] OP_LBI  = 4'b1111;

    localparam logic [1:0] HOLD_LAST = 2'(RESET_STATE_HOLD - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_opcode;
    logic [1:0]  r_hold_cnt;
    logic [15:0] r_retire_cnt;
    logic        w_retire;

    always_ff @(posedge In_Clk) begin
        if (In_Rst) begin
            r_state      <= S_IDLE;
            r_opcode     <= 4'd0;
            r_hold_cnt   <= 2'd0;
            r_retire_cnt <= 16'd0;
        end else begin
            r_state    <= w_next;
            r_hold_cnt <= (r_state == S_IDLE) ? r_hold_cnt + 2'd1 : 2'd0;
            if (r_state == S_DECODE)
                r_opcode <= In_Opcode;
            if (w_retire)
                r_retire_cnt <= r_retire_cnt + 16'd1;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        Out_MemReq   = 1'b0;
        Out_MemWrite = 1'b0;
        Out_IorD     = 1'b0;
        Out_IRWrite  = 1'b0;
        Out_PCWrite  = 1'b0;
        Out_PCSrc    = 2'b00;
        Out_ALUOp    = 2'b00;
        Out_ALUSrcB  = 2'b00;
        Out_RegWrite = 1'b0;
        Out_WBSel    = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (r_hold_cnt == HOLD_LAST)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                Out_MemReq = 1'b1;
                if (In_MemReady) begin
                    Out_IRWrite = 1'b1;
                    Out_PCWrite = 1'b1;
                    Out_ALUSrcB = 2'b10;
                    w_next      = S_DECODE;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                case (r_opcode)
                    OP_R: w_next = S_WB;
                    OP_ADDI: begin
                        Out_ALUSrcB = 2'b01;
                        w_next      = S_WB;
                    end
                    OP_SI: begin
                        Out_ALUOp   = 2'b11;
                        Out_ALUSrcB = 2'b01;
                        w_next      = S_WB;
                    end
                    OP_LUI, OP_LBI: begin
                        Out_ALUOp   = 2'b10;
                        Out_ALUSrcB = 2'b01;
                        w_next      = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        Out_ALUSrcB = 2'b01;
                        w_next      = S_MEM;
                    end
                    OP_BEQ: begin
                        Out_ALUOp   = 2'b01;
                        Out_PCWrite = In_Zero;
                        Out_PCSrc   = 2'b01;
                        w_retire    = 1'b1;
                        w_next      = S_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        Out_RegWrite = 1'b1;
                        Out_WBSel    = 2'b10;
                        Out_PCWrite  = 1'b1;
                        Out_PCSrc    = (r_opcode == OP_JAL) ? 2'b10 : 2'b11;
                        w_retire     = 1'b1;
                        w_next       = S_FETCH;
                    end
                    default: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
                        w_next   = S_HALT;
`else
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                Out_MemReq   = 1'b1;
                Out_IorD     = 1'b1;
                Out_MemWrite = (r_opcode == OP_SW);
                if (In_MemReady) begin
                    // stores finish here; loads still need the write-back cycle
                    w_retire = (r_opcode == OP_SW);
                    w_next   = (r_opcode == OP_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                Out_RegWrite = 1'b1;
                Out_WBSel    = (r_opcode == OP_LW) ? 2'b01 : 2'b00;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    assign Out_Retire      = w_retire;
    assign Out_RetireCount = r_retire_cnt;
    assign Out_State       = r_state;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: per-opcode vector table plus stall, reset and wrap sequences.
module tb_proc_control_fsm;

    logic        In_Clk = 1'b0;
    logic        In_Rst = 1'b1;
    logic [3:0]  In_Opcode = 4'd0;
    logic        In_Zero = 1'b0;
    logic        In_MemReady = 1'b1;
    logic        Out_MemReq, Out_MemWrite, Out_IorD, Out_IRWrite, Out_PCWrite;
    logic [1:0]  Out_PCSrc, Out_ALUOp, Out_ALUSrcB, Out_WBSel;
    logic        Out_RegWrite, Out_Retire;
    logic [15:0] Out_RetireCount;
    logic [2:0]  Out_State;

    proc_control_fsm #(.RESET_STATE_HOLD(1)) dut (
        .In_Clk(In_Clk), .In_Rst(In_Rst), .In_Opcode(In_Opcode), .In_Zero(In_Zero),
        .In_MemReady(In_MemReady), .Out_MemReq(Out_MemReq), .Out_MemWrite(Out_MemWrite),
        .Out_IorD(Out_IorD), .Out_IRWrite(Out_IRWrite), .Out_PCWrite(Out_PCWrite),
        .Out_PCSrc(Out_PCSrc), .Out_ALUOp(Out_ALUOp), .Out_ALUSrcB(Out_ALUSrcB),
        .Out_RegWrite(Out_RegWrite), .Out_WBSel(Out_WBSel), .Out_Retire(Out_Retire),
        .Out_RetireCount(Out_RetireCount), .Out_State(Out_State)
    );

    always #5 In_Clk = ~In_Clk;

    typedef struct {
        logic [3:0] op;
        logic       zero;
        int         cyc;
        logic       regwr;
        logic [1:0] wbsel;
        logic       pcwr;
        logic [1:0] pcsrc;
        logic       memwr;
        logic [1:0] aluop;
        logic [1:0] srcb;
    } vec_t;

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    localparam int NV = 11;
`else
    localparam int NV = 12;
`endif

    vec_t        vt[12];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] m_cnt = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] strobes();
        return {Out_MemReq, Out_MemWrite, Out_IorD, Out_IRWrite, Out_PCWrite, Out_PCSrc,
                Out_ALUOp, Out_ALUSrcB, Out_RegWrite, Out_WBSel, Out_Retire};
    endfunction

    task automatic tick();
        @(posedge In_Clk);
        #1;
    endtask

    task automatic advance_to(input logic [2:0] s, input string tag);
        for (int k = 0; k < 20 && Out_State != s; k++)
            tick();
        chk({tag, " reach state"}, 32'(Out_State), 32'(s));
    endtask

    // Runs one instruction from a FETCH cycle; corrupts In_Opcode after DECODE to prove it is latched.
    task automatic run_instr(input vec_t v, input string tag);
        int         cyc = 0;
        logic       got = 1'b0;
        logic       scramble;
        logic [1:0] ex_aluop = 2'b00, ex_srcb = 2'b00, wbsel = 2'b00, pcsrc = 2'b00;
        logic       regwr = 1'b0, pcwr = 1'b0, memwr = 1'b0;
        In_Opcode = v.op;
        In_Zero   = v.zero;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge In_Clk);
            if (Out_State == 3'd3) begin
                ex_aluop = Out_ALUOp;
                ex_srcb  = Out_ALUSrcB;
            end
            if (Out_Retire) begin
                got   = 1'b1;
                cyc   = c;
                regwr = Out_RegWrite;
                wbsel = Out_WBSel;
                pcwr  = Out_PCWrite;
                pcsrc = Out_PCSrc;
                memwr = Out_MemWrite;
            end
            scramble = (Out_State == 3'd2);
            tick();
            if (scramble)
                In_Opcode = v.op ^ 4'hF;
        end
        if (got)
            m_cnt = m_cnt + 16'd1;
        chk({tag, " cycles"}, 32'(cyc), 32'(v.cyc));
        chk({tag, " regwrite"}, 32'(regwr), 32'(v.regwr));
        chk({tag, " wbsel"}, 32'(wbsel), 32'(v.wbsel));
        chk({tag, " pcwrite"}, 32'(pcwr), 32'(v.pcwr));
        chk({tag, " pcsrc"}, 32'(pcsrc), 32'(v.pcsrc));
        chk({tag, " memwrite"}, 32'(memwr), 32'(v.memwr));
        chk({tag, " exec aluop"}, 32'(ex_aluop), 32'(v.aluop));
        chk({tag, " exec alusrcb"}, 32'(ex_srcb), 32'(v.srcb));
        chk({tag, " back to fetch"}, 32'(Out_State), 32'd1);
        chk({tag, " retire count"}, 32'(Out_RetireCount), 32'(m_cnt));
        In_Opcode = v.op;
    endtask

    task automatic finish_retire(input string tag);
        logic got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge In_Clk);
            got = Out_Retire;
            tick();
        end
        if (got)
            m_cnt = m_cnt + 16'd1;
        chk({tag, " retired"}, 32'(got), 32'd1);
        chk({tag, " retire count"}, 32'(Out_RetireCount), 32'(m_cnt));
    endtask

    initial begin
        int mreq, mw, rw;
        //        op       z  cyc rw wbsel  pw pcsrc  mw aluop  srcb
        vt[0]  = '{4'b0000, 0, 4, 1, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00};
        vt[1]  = '{4'b0111, 0, 5, 1, 2'b01, 0, 2'b00, 0, 2'b00, 2'b01};
        vt[2]  = '{4'b0100, 0, 4, 1, 2'b00, 0, 2'b00, 0, 2'b00, 2'b01};
        vt[3]  = '{4'b0101, 0, 4, 1, 2'b00, 0, 2'b00, 0, 2'b11, 2'b01};
        vt[4]  = '{4'b1110, 0, 4, 1, 2'b00, 0, 2'b00, 0, 2'b10, 2'b01};
        vt[5]  = '{4'b1111, 0, 4, 1, 2'b00, 0, 2'b00, 0, 2'b10, 2'b01};
        vt[6]  = '{4'b1000, 0, 4, 0, 2'b00, 0, 2'b00, 1, 2'b00, 2'b01};
        vt[7]  = '{4'b1001, 1, 3, 0, 2'b00, 1, 2'b01, 0, 2'b01, 2'b00};
        vt[8]  = '{4'b1001, 0, 3, 0, 2'b00, 0, 2'b01, 0, 2'b01, 2'b00};
        vt[9]  = '{4'b1100, 0, 3, 1, 2'b10, 1, 2'b10, 0, 2'b00, 2'b00};
        vt[10] = '{4'b0110, 0, 3, 1, 2'b10, 1, 2'b11, 0, 2'b00, 2'b00};
        vt[11] = '{4'b0010, 0, 3, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00};

        // reset for two cycles, then one IDLE hold cycle, then FETCH
        In_Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset state", 32'(Out_State), 32'd0);
            chk("reset strobes", 32'(strobes()), 32'd0);
        end
        chk("reset count", 32'(Out_RetireCount), 32'd0);
        In_Rst = 1'b0;
        #1;
        chk("idle hold state", 32'(Out_State), 32'd0);
        chk("idle hold strobes", 32'(strobes()), 32'd0);
        tick();
        chk("first fetch state", 32'(Out_State), 32'd1);
        chk("first fetch memreq", 32'(Out_MemReq), 32'd1);

        for (int i = 0; i < NV; i++)
            run_instr(vt[i], $sformatf("vec%0d", i));

        // FETCH stalled three cycles
        In_Opcode = 4'b0000;
        In_MemReady = 1'b0;
        mreq = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge In_Clk);
            mreq += int'(Out_MemReq);
            chk("fetch stall ir/pc write", 32'({Out_IRWrite, Out_PCWrite}), 32'd0);
            tick();
        end
        In_MemReady = 1'b1;
        @(negedge In_Clk);
        mreq += int'(Out_MemReq);
        chk("fetch ready strobes",
            32'({Out_IRWrite, Out_PCWrite, Out_IorD, Out_PCSrc, Out_ALUSrcB, Out_ALUOp}),
            32'(9'b1_1_0_00_10_00));
        chk("fetch memreq cycles", 32'(mreq), 32'd4);
        tick();
        chk("fetch stall to decode", 32'(Out_State), 32'd2);
        finish_retire("fetch stall add");

        // sw with two MEM wait cycles
        In_Opcode = 4'b1000;
        advance_to(3'd4, "sw stall");
        In_MemReady = 1'b0;
        mw = 0;
        rw = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2)
                In_MemReady = 1'b1;
            @(negedge In_Clk);
            mw += int'(Out_MemReq & Out_MemWrite & Out_IorD);
            rw += int'(Out_RegWrite);
            chk($sformatf("sw stall retire c%0d", i), 32'(Out_Retire), (i == 2) ? 32'd1 : 32'd0);
            tick();
        end
        m_cnt = m_cnt + 16'd1;
        chk("sw stall memwrite cycles", 32'(mw), 32'd3);
        chk("sw stall regwrite", 32'(rw), 32'd0);
        chk("sw stall back to fetch", 32'(Out_State), 32'd1);
        chk("sw stall count", 32'(Out_RetireCount), 32'(m_cnt));

        // reset while lw waits in MEM
        In_Opcode = 4'b0111;
        advance_to(3'd4, "lw reset");
        In_MemReady = 1'b0;
        @(negedge In_Clk);
        chk("mem before reset memreq", 32'(Out_MemReq), 32'd1);
        In_Rst = 1'b1;
        tick();
        m_cnt = 16'd0;
        chk("mem reset memreq", 32'(Out_MemReq), 32'd0);
        chk("mem reset state", 32'(Out_State), 32'd0);
        chk("mem reset count", 32'(Out_RetireCount), 32'd0);
        In_Rst = 1'b0;
        In_MemReady = 1'b1;
        tick();
        chk("post reset fetch", 32'(Out_State), 32'd1);

        // counter wrap: preload near the top instead of retiring 65534 times
        force dut.r_retire_cnt = 16'hFFFE;
        #1;
        release dut.r_retire_cnt;
        m_cnt = 16'hFFFE;
        run_instr(vt[8], "wrap beq a");
        run_instr(vt[8], "wrap beq b");
        chk("wrap to zero", 32'(Out_RetireCount), 32'd0);

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        In_Opcode = 4'b0010;
        advance_to(3'd3, "illegal");
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("halt state", 32'(Out_State), 32'd6);
            chk("halt strobes", 32'(strobes()), 32'd0);
            tick();
        end
        chk("halt count", 32'(Out_RetireCount), 32'(m_cnt));
        In_Rst = 1'b1;
        tick();
        In_Rst = 1'b0;
        m_cnt = 16'd0;
        chk("halt reset state", 32'(Out_State), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
